// File: rtl/beam_event_counter.sv
// Break-beam object counter: synchronizes and debounces the receiver output,
// counts beam-break events in 4-digit BCD and drives four seven-segment displays.
module beam_event_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sense,
  input  logic        clr,
  output logic        beam_blocked,
  output logic        obj_pulse,
  output logic [15:0] count_bcd,
  output logic        overflow,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam int DB_W = 24;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer; resets to the beam-intact level.
  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
    end else begin
      s1_reg <= sense;
      s2_reg <= s1_reg;
    end
  end

  logic            level_reg;
  logic            level_next;
  logic [DB_W-1:0] db_cnt_reg;
  logic [DB_W-1:0] db_cnt_next;
  logic            fall_event;
  logic            blocked_reg;

  // The level follows s2 only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    level_next  = level_reg;
    db_cnt_next = '0;
    fall_event  = 1'b0;
    if (s2_reg != level_reg) begin
      if (db_cnt_reg == DB_LAST) begin
        level_next = s2_reg;
        fall_event = level_reg & ~s2_reg;
      end else begin
        db_cnt_next = db_cnt_reg + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg   <= 1'b1;
      db_cnt_reg  <= '0;
      blocked_reg <= 1'b0;
    end else begin
      level_reg   <= level_next;
      db_cnt_reg  <= db_cnt_next;
      blocked_reg <= ~level_next;
    end
  end

  logic [15:0] count_reg;
  logic [15:0] count_inc;
  logic [4:0]  carry;
  logic        overflow_reg;
  logic        pulse_reg;
  logic [6:0]  hex_vec [4];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign carry[0] = 1'b1;

  // Ripple BCD incrementer: each digit wraps 9->0 and carries into the next.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = count_reg[gi*4 +: 4];
      assign count_inc[gi*4 +: 4] = !carry[gi] ? digit :
                                    (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      assign carry[gi+1] = carry[gi] & (digit == 4'd9);
      assign hex_vec[gi] = seg7(digit);
    end
  endgenerate

  // clr wins over a coincident event, but the strobe still fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      pulse_reg    <= 1'b0;
    end else begin
      pulse_reg <= fall_event;
      if (clr) begin
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else if (fall_event) begin
        count_reg <= count_inc;
        if (carry[4]) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign beam_blocked = blocked_reg;
  assign obj_pulse    = pulse_reg;
  assign count_bcd    = count_reg;
  assign overflow     = overflow_reg;
  assign hex0         = hex_vec[0];
  assign hex1         = hex_vec[1];
  assign hex2         = hex_vec[2];
  assign hex3         = hex_vec[3];

endmodule

// File: tb/tb_beam_event_counter.sv
// Bench for beam_event_counter: two instances (debounce 4 and 2) share stimulus
// and are compared against a sliding-window behavioural model.
module tb_beam_event_counter;
  localparam int DA = 4;
  localparam int DB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sense = 1'b1;
  logic clr = 1'b0;

  logic        a_blocked, a_pulse, a_ovf;
  logic [15:0] a_count;
  logic [6:0]  a_hex0, a_hex1, a_hex2, a_hex3;
  logic        b_blocked, b_pulse, b_ovf;
  logic [15:0] b_count;
  logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3;

  always #5 clk = ~clk;

  beam_event_counter #(.DEBOUNCE_CYCLES(DA)) u_dut_a (
    .clk(clk), .rst(rst), .sense(sense), .clr(clr),
    .beam_blocked(a_blocked), .obj_pulse(a_pulse), .count_bcd(a_count),
    .overflow(a_ovf), .hex0(a_hex0), .hex1(a_hex1), .hex2(a_hex2), .hex3(a_hex3)
  );

  beam_event_counter #(.DEBOUNCE_CYCLES(DB)) u_dut_b (
    .clk(clk), .rst(rst), .sense(sense), .clr(clr),
    .beam_blocked(b_blocked), .obj_pulse(b_pulse), .count_bcd(b_count),
    .overflow(b_ovf), .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3)
  );

  int vec = 0;
  int err = 0;

  // Model: sense samples per edge; the debounced level flips when the last
  // D synchronized samples (two edges old) all disagree with it.
  int hist[$];
  int dlen[2] = '{DA, DB};
  int m_level[2], m_count[2], m_ovf[2], m_pulse[2], m_blocked[2];
  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic tick();
    bit flip;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      repeat (8) hist.push_back(1);
      for (int i = 0; i < 2; i++) begin
        m_level[i] = 1; m_count[i] = 0; m_ovf[i] = 0; m_pulse[i] = 0; m_blocked[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        flip = 1'b1;
        for (int j = 0; j < dlen[i]; j++)
          if (hist[hist.size() - 2 - j] == m_level[i]) flip = 1'b0;
        m_pulse[i] = (flip && m_level[i] == 1) ? 1 : 0;
        if (flip) m_level[i] = 1 - m_level[i];
        m_blocked[i] = 1 - m_level[i];
        if (clr) begin
          m_count[i] = 0; m_ovf[i] = 0;
        end else if (m_pulse[i] == 1) begin
          if (m_count[i] == 9999) begin m_count[i] = 0; m_ovf[i] = 1; end
          else m_count[i]++;
        end
      end
      hist.push_back(int'(sense));
      if (hist.size() > 16) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic obj_a();
    sense = 1'b0; repeat (6) tick();
    sense = 1'b1; repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; sense = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    vec++; if (a_blocked !== 1'b0) begin err++; $display("FAIL reset_blocked: got %b expected 0", a_blocked); end
    vec++; if (a_pulse !== 1'b0) begin err++; $display("FAIL reset_pulse: got %b expected 0", a_pulse); end
    vec++; if (a_count !== 16'h0000) begin err++; $display("FAIL reset_count: got %h expected 0000", a_count); end
    vec++; if (a_ovf !== 1'b0) begin err++; $display("FAIL reset_ovf: got %b expected 0", a_ovf); end
    vec++; if ({a_hex3, a_hex2, a_hex1, a_hex0} !== {4{7'b1000000}}) begin
      err++; $display("FAIL reset_hex: got %b %b %b %b expected 1000000 x4", a_hex3, a_hex2, a_hex1, a_hex0);
    end
    vec++; if (b_count !== 16'h0000 || b_ovf !== 1'b0) begin
      err++; $display("FAIL reset_b: got count %h ovf %b expected 0000 0", b_count, b_ovf);
    end
    rst = 1'b0;
    repeat (9) tick();
  endtask

  task automatic test_latency();
    sense = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      tick();
      vec++; if (a_pulse !== (t == 5)) begin err++; $display("FAIL latency_pulse t=%0d: got %b expected %b", t, a_pulse, (t == 5)); end
      vec++; if (a_blocked !== (t >= 5)) begin err++; $display("FAIL latency_blocked t=%0d: got %b expected %b", t, a_blocked, (t >= 5)); end
      vec++; if (a_count !== ((t >= 5) ? 16'h0001 : 16'h0000)) begin
        err++; $display("FAIL latency_count t=%0d: got %h expected %h", t, a_count, (t >= 5) ? 16'h0001 : 16'h0000);
      end
    end
    sense = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      vec++; if (a_pulse !== 1'b0) begin err++; $display("FAIL rise_pulse t=%0d: got %b expected 0", t, a_pulse); end
    end
    vec++; if (a_blocked !== 1'b0 || a_count !== 16'h0001) begin
      err++; $display("FAIL rise_state: got blocked %b count %h expected 0 0001", a_blocked, a_count);
    end
  endtask

  task automatic test_glitch();
    clr = 1'b1; tick(); clr = 1'b0;
    vec++; if (a_count !== 16'h0000) begin err++; $display("FAIL clr_count: got %h expected 0000", a_count); end
    sense = 1'b0; repeat (3) tick();
    sense = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      vec++; if (a_pulse !== 1'b0 || a_blocked !== 1'b0 || a_count !== 16'h0000) begin
        err++; $display("FAIL glitch t=%0d: got pulse %b blocked %b count %h expected 0 0 0000", t, a_pulse, a_blocked, a_count);
      end
    end
  endtask

  task automatic test_bcd_carry();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (9) obj_a();
    vec++; if (a_count !== 16'h0009 || a_count !== to_bcd(m_count[0])) begin
      err++; $display("FAIL preload9: got %h expected 0009", a_count);
    end
    obj_a();
    vec++; if (a_count !== 16'h0010) begin err++; $display("FAIL carry10: got %h expected 0010", a_count); end
    vec++; if (a_hex1 !== 7'b1111001 || a_hex0 !== 7'b1000000) begin
      err++; $display("FAIL carry10_hex: got %b %b expected 1111001 1000000", a_hex1, a_hex0);
    end
  endtask

  task automatic test_clr_collision();
    sense = 1'b0; repeat (5) tick();
    clr = 1'b1; tick();
    vec++; if (a_pulse !== 1'b1 || a_count !== 16'h0000 || a_ovf !== 1'b0) begin
      err++; $display("FAIL clr_collide: got pulse %b count %h ovf %b expected 1 0000 0", a_pulse, a_count, a_ovf);
    end
    clr = 1'b0; tick();
    vec++; if (a_pulse !== 1'b0 || a_count !== 16'h0000) begin
      err++; $display("FAIL clr_collide_after: got pulse %b count %h expected 0 0000", a_pulse, a_count);
    end
    sense = 1'b1; repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    sense = 1'b0; repeat (4) tick();
    rst = 1'b1; repeat (2) tick();
    vec++; if (a_blocked !== 1'b0 || a_pulse !== 1'b0 || a_count !== 16'h0000) begin
      err++; $display("FAIL rstmid_in_reset: got blocked %b pulse %b count %h expected 0 0 0000", a_blocked, a_pulse, a_count);
    end
    rst = 1'b0;
    for (int t = 1; t <= DA + 2; t++) begin
      tick();
      vec++; if (a_pulse !== (t == DA + 2) || a_blocked !== (t == DA + 2)) begin
        err++; $display("FAIL rstmid_t%0d: got pulse %b blocked %b expected %b", t, a_pulse, a_blocked, (t == DA + 2));
      end
    end
    vec++; if (a_count !== 16'h0001) begin err++; $display("FAIL rstmid_count: got %h expected 0001", a_count); end
    sense = 1'b1; repeat (8) tick();
  endtask

  task automatic test_random();
    int run_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        sense = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      clr = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      vec++; if (a_pulse !== 1'(m_pulse[0]) || a_blocked !== 1'(m_blocked[0]) || a_count !== to_bcd(m_count[0]) || a_ovf !== 1'(m_ovf[0])) begin
        err++; $display("FAIL rand_a n=%0d: got p%b b%b c%h o%b expected p%0d b%0d c%h o%0d",
                        n, a_pulse, a_blocked, a_count, a_ovf, m_pulse[0], m_blocked[0], to_bcd(m_count[0]), m_ovf[0]);
      end
      vec++; if (b_pulse !== 1'(m_pulse[1]) || b_blocked !== 1'(m_blocked[1]) || b_count !== to_bcd(m_count[1]) || b_ovf !== 1'(m_ovf[1])) begin
        err++; $display("FAIL rand_b n=%0d: got p%b b%b c%h o%b expected p%0d b%0d c%h o%0d",
                        n, b_pulse, b_blocked, b_count, b_ovf, m_pulse[1], m_blocked[1], to_bcd(m_count[1]), m_ovf[1]);
      end
      vec++; if (a_hex0 !== seg_ref[m_count[0] % 10] || a_hex1 !== seg_ref[m_count[0] / 10 % 10] ||
                 a_hex2 !== seg_ref[m_count[0] / 100 % 10] || a_hex3 !== seg_ref[m_count[0] / 1000 % 10]) begin
        err++; $display("FAIL rand_hex n=%0d: got %b %b %b %b for count %0d", n, a_hex3, a_hex2, a_hex1, a_hex0, m_count[0]);
      end
    end
    rst = 1'b0; clr = 1'b0; sense = 1'b1;
    repeat (12) tick();
  endtask

  task automatic event_b();
    sense = 1'b0; repeat (2) tick();
    sense = 1'b1; repeat (2) tick();
  endtask

  task automatic test_wrap();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int n = 1; n <= 9999; n++) begin
      event_b();
      if (n % 1000 == 0) begin
        vec++; if (b_count !== to_bcd(n) || b_count !== to_bcd(m_count[1])) begin
          err++; $display("FAIL wrap_progress n=%0d: got %h expected %h", n, b_count, to_bcd(n));
        end
      end
    end
    vec++; if (b_count !== 16'h9999 || b_ovf !== 1'b0) begin
      err++; $display("FAIL wrap_9999: got %h ovf %b expected 9999 0", b_count, b_ovf);
    end
    event_b();
    vec++; if (b_count !== 16'h0000 || b_ovf !== 1'b1) begin
      err++; $display("FAIL wrap_0000: got %h ovf %b expected 0000 1", b_count, b_ovf);
    end
    vec++; if (b_hex3 !== 7'b1000000 || b_hex0 !== 7'b1000000) begin
      err++; $display("FAIL wrap_hex: got %b %b expected 1000000 1000000", b_hex3, b_hex0);
    end
    event_b();
    vec++; if (b_count !== 16'h0001 || b_ovf !== 1'b1) begin
      err++; $display("FAIL wrap_sticky: got %h ovf %b expected 0001 1", b_count, b_ovf);
    end
    vec++; if (a_count !== to_bcd(m_count[0]) || a_ovf !== 1'(m_ovf[0])) begin
      err++; $display("FAIL wrap_a_quiet: got %h ovf %b expected %h %0d", a_count, a_ovf, to_bcd(m_count[0]), m_ovf[0]);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    vec++; if (b_count !== 16'h0000 || b_ovf !== 1'b0) begin
      err++; $display("FAIL wrap_clr: got %h ovf %b expected 0000 0", b_count, b_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_bcd_carry();
    test_clr_collision();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
